// File: rtl/median_filter_pkg.sv
// Shared constants and types for the streaming 3x3 median filter.
//   DEF_DATA_W : default pixel width (DATA_W default of the top).
//   WIN        : window edge length (3 pixels per column, 3 columns).
//   pixel_t    : pixel type at the default width.
package median_filter_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned WIN        = 3;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/median_filter_3x3_sort3.sv
// Combinational 3-input unsigned sorter (the sort3 building block).
// Ports:
//   i_a, i_b, i_c : inputs to sort.
//   o_lo_c        : smallest input.
//   o_mid_c       : middle input.
//   o_hi_c        : largest input.
module median_filter_3x3_sort3
    import median_filter_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    output logic [DATA_W-1:0] o_lo_c,
    output logic [DATA_W-1:0] o_mid_c,
    output logic [DATA_W-1:0] o_hi_c
);

    logic [DATA_W-1:0] w_ab_lo;
    logic [DATA_W-1:0] w_ab_hi;
    logic [DATA_W-1:0] w_t;

    // Three compare-exchange stages: (a,b), (hi,c), (lo,t).
    always_comb begin
        w_ab_lo = (i_b < i_a) ? i_b : i_a;
        w_ab_hi = (i_b < i_a) ? i_a : i_b;
        o_hi_c  = (i_c > w_ab_hi) ? i_c : w_ab_hi;
        w_t     = (i_c > w_ab_hi) ? w_ab_hi : i_c;
        o_lo_c  = (w_t < w_ab_lo) ? w_t : w_ab_lo;
        o_mid_c = (w_t < w_ab_lo) ? w_ab_lo : w_t;
    end

endmodule

// File: rtl/median_filter_3x3.sv
// Streaming 3x3 median filter.
// Pixels are shifted into a 3-entry column register with en1; en2 commits the
// column into a 3-column sliding window. A 3-stage sorting pipeline produces
// the median three cycles after a commit.
// Optional feature macro: MEDIAN_FILTER_MINMAX_EN adds o_min/o_max.
// Ports:
//   clk     : rising-edge clock.
//   rst_n   : asynchronous active-low reset.
//   i_data  : input pixel, sampled when en1=1.
//   en1     : shift i_data into the column register.
//   en2     : commit the column (with en1 bypass) into the window.
//   o_med   : registered window median.
//   o_valid : o_med reflects a fully populated window.
//   o_min   : window minimum (MEDIAN_FILTER_MINMAX_EN only).
//   o_max   : window maximum (MEDIAN_FILTER_MINMAX_EN only).
module median_filter_3x3
    import median_filter_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic              en1,
    input  logic              en2,
    output logic [DATA_W-1:0] o_med,
    output logic              o_valid
`ifdef MEDIAN_FILTER_MINMAX_EN
    ,
    output logic [DATA_W-1:0] o_min,
    output logic [DATA_W-1:0] o_max
`endif
);

    localparam int unsigned FILL_W = $clog2(WIN + 1);

    // Column register, window (r_win[column][row]) and fill count.
    logic [DATA_W-1:0] r_col [WIN];
    logic [DATA_W-1:0] r_win [WIN][WIN];
    logic [FILL_W-1:0] r_fill;
    logic [DATA_W-1:0] w_commit [WIN];
    logic              w_full;

    // Stage 1: per-column sorted values.
    logic [DATA_W-1:0] w_s1_lo  [WIN];
    logic [DATA_W-1:0] w_s1_mid [WIN];
    logic [DATA_W-1:0] w_s1_hi  [WIN];
    logic [DATA_W-1:0] r_s1_lo  [WIN];
    logic [DATA_W-1:0] r_s1_mid [WIN];
    logic [DATA_W-1:0] r_s1_hi  [WIN];
    logic              r_s1_full;

    // Stage 2: row reductions.
    logic [DATA_W-1:0] w_lo_min, w_lo_mid, w_lo_max;
    logic [DATA_W-1:0] w_mid_lo, w_mid_mid, w_mid_hi;
    logic [DATA_W-1:0] w_hi_min, w_hi_mid, w_hi_max;
    logic [DATA_W-1:0] r_s2_lo, r_s2_mid, r_s2_hi;
    logic              r_s2_full;

    // Stage 3: final median of three.
    logic [DATA_W-1:0] w_med_lo, w_med_mid, w_med_hi;

    // Commit column; with en1 the incoming pixel is bypassed into the newest slot.
    assign w_commit[0] = en1 ? r_col[1] : r_col[0];
    assign w_commit[1] = en1 ? r_col[2] : r_col[1];
    assign w_commit[2] = en1 ? i_data   : r_col[2];

    assign w_full = (r_fill == FILL_W'(WIN));

    // Column register, window shift and fill counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                r_col[i] <= '0;
                for (int j = 0; j < WIN; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_fill <= '0;
        end else begin
            if (en1) begin
                r_col[0] <= r_col[1];
                r_col[1] <= r_col[2];
                r_col[2] <= i_data;
            end
            if (en2) begin
                for (int j = 0; j < WIN; j++) begin
                    r_win[0][j] <= r_win[1][j];
                    r_win[1][j] <= r_win[2][j];
                    r_win[2][j] <= w_commit[j];
                end
                if (!w_full) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end
        end
    end

    // Stage 1 sorters, one per window column.
    for (genvar g = 0; g < WIN; g++) begin : g_col_sort
        median_filter_3x3_sort3 #(.DATA_W(DATA_W)) u_col_sort (
            .i_a     (r_win[g][0]),
            .i_b     (r_win[g][1]),
            .i_c     (r_win[g][2]),
            .o_lo_c  (w_s1_lo[g]),
            .o_mid_c (w_s1_mid[g]),
            .o_hi_c  (w_s1_hi[g])
        );
    end

    // Stage 2 reductions: max of lows, median of mids, min of highs.
    median_filter_3x3_sort3 #(.DATA_W(DATA_W)) u_lo_sort (
        .i_a     (r_s1_lo[0]),
        .i_b     (r_s1_lo[1]),
        .i_c     (r_s1_lo[2]),
        .o_lo_c  (w_lo_min),
        .o_mid_c (w_lo_mid),
        .o_hi_c  (w_lo_max)
    );

    median_filter_3x3_sort3 #(.DATA_W(DATA_W)) u_mid_sort (
        .i_a     (r_s1_mid[0]),
        .i_b     (r_s1_mid[1]),
        .i_c     (r_s1_mid[2]),
        .o_lo_c  (w_mid_lo),
        .o_mid_c (w_mid_mid),
        .o_hi_c  (w_mid_hi)
    );

    median_filter_3x3_sort3 #(.DATA_W(DATA_W)) u_hi_sort (
        .i_a     (r_s1_hi[0]),
        .i_b     (r_s1_hi[1]),
        .i_c     (r_s1_hi[2]),
        .o_lo_c  (w_hi_min),
        .o_mid_c (w_hi_mid),
        .o_hi_c  (w_hi_max)
    );

    // Stage 3 median of the three stage-2 candidates.
    median_filter_3x3_sort3 #(.DATA_W(DATA_W)) u_med_sort (
        .i_a     (r_s2_lo),
        .i_b     (r_s2_mid),
        .i_c     (r_s2_hi),
        .o_lo_c  (w_med_lo),
        .o_mid_c (w_med_mid),
        .o_hi_c  (w_med_hi)
    );

    // Free-running pipeline; window_full travels alongside the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                r_s1_lo[i]  <= '0;
                r_s1_mid[i] <= '0;
                r_s1_hi[i]  <= '0;
            end
            r_s1_full <= 1'b0;
            r_s2_lo   <= '0;
            r_s2_mid  <= '0;
            r_s2_hi   <= '0;
            r_s2_full <= 1'b0;
            o_med     <= '0;
            o_valid   <= 1'b0;
        end else begin
            for (int i = 0; i < WIN; i++) begin
                r_s1_lo[i]  <= w_s1_lo[i];
                r_s1_mid[i] <= w_s1_mid[i];
                r_s1_hi[i]  <= w_s1_hi[i];
            end
            r_s1_full <= w_full;
            r_s2_lo   <= w_lo_max;
            r_s2_mid  <= w_mid_mid;
            r_s2_hi   <= w_hi_min;
            r_s2_full <= r_s1_full;
            o_med     <= w_med_mid;
            o_valid   <= r_s2_full;
        end
    end

`ifdef MEDIAN_FILTER_MINMAX_EN
    // Window min is the min of column lows; max is the max of column highs.
    logic [DATA_W-1:0] r_s2_min;
    logic [DATA_W-1:0] r_s2_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_min <= '0;
            r_s2_max <= '0;
            o_min    <= '0;
            o_max    <= '0;
        end else begin
            r_s2_min <= w_lo_min;
            r_s2_max <= w_hi_max;
            o_min    <= r_s2_min;
            o_max    <= r_s2_max;
        end
    end

    logic w_unused;
    assign w_unused = ^{w_lo_mid, w_mid_lo, w_mid_hi, w_hi_mid, w_med_lo, w_med_hi};
`else
    logic w_unused;
    assign w_unused = ^{w_lo_min, w_lo_mid, w_mid_lo, w_mid_hi, w_hi_mid, w_hi_max,
                        w_med_lo, w_med_hi};
`endif

endmodule

// File: tb/tb_median_filter_3x3.sv
// Directed + randomized bench for median_filter_3x3 with a sorting-based
// reference model of the column register, window and 3-cycle output latency.
// Optional feature macro: MEDIAN_FILTER_MINMAX_EN (checks o_min/o_max too).
module tb_median_filter_3x3;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_data;
    logic       en1;
    logic       en2;
    logic [7:0] o_med;
    logic       o_valid;
`ifdef MEDIAN_FILTER_MINMAX_EN
    logic [7:0] o_min;
    logic [7:0] o_max;
`endif

    median_filter_3x3 #(.DATA_W(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_data  (i_data),
        .en1     (en1),
        .en2     (en2),
        .o_med   (o_med),
        .o_valid (o_valid)
`ifdef MEDIAN_FILTER_MINMAX_EN
        ,
        .o_min   (o_min),
        .o_max   (o_max)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int med;
        int mn;
        int mx;
        int full;
    } exp_t;

    // Reference model state.
    int   m_col [3];
    int   m_win [3][3];
    int   m_fill;
    exp_t hist [$];

    task automatic chk(input string tag, input logic [31:0] got, input int exp_v);
        checks++;
        assert (got === 32'(exp_v)) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp_v);
        end
    endtask

    function automatic exp_t window_result();
        int   v [9];
        int   t;
        exp_t r;
        for (int c = 0; c < 3; c++)
            for (int k = 0; k < 3; k++)
                v[c*3+k] = m_win[c][k];
        for (int a = 0; a < 9; a++)
            for (int b = 0; b < 8 - a; b++)
                if (v[b] > v[b+1]) begin
                    t = v[b]; v[b] = v[b+1]; v[b+1] = t;
                end
        r.med  = v[4];
        r.mn   = v[0];
        r.mx   = v[8];
        r.full = (m_fill == 3) ? 1 : 0;
        return r;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_col[c] = 0;
            for (int k = 0; k < 3; k++) m_win[c][k] = 0;
        end
        m_fill = 0;
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back('{0, 0, 0, 0});
    endtask

    task automatic model_clock(input bit e1, input bit e2, input int d);
        int nc [3];
        if (e2) begin
            if (e1) begin nc[0] = m_col[1]; nc[1] = m_col[2]; nc[2] = d; end
            else    begin nc[0] = m_col[0]; nc[1] = m_col[1]; nc[2] = m_col[2]; end
            for (int k = 0; k < 3; k++) begin
                m_win[0][k] = m_win[1][k];
                m_win[1][k] = m_win[2][k];
                m_win[2][k] = nc[k];
            end
            if (m_fill < 3) m_fill++;
        end
        if (e1) begin
            m_col[0] = m_col[1];
            m_col[1] = m_col[2];
            m_col[2] = d;
        end
        hist.push_back(window_result());
    endtask

    // One clock: drive, advance model, check outputs against the value 3 edges old.
    task automatic step(input bit e1, input bit e2, input int d);
        exp_t e;
        en1    = e1;
        en2    = e2;
        i_data = 8'(d);
        @(posedge clk);
        model_clock(e1, e2, d);
        #1;
        e = hist.pop_front();
        chk("model_med", 32'(o_med), e.med);
        chk("model_valid", 32'(o_valid), e.full);
`ifdef MEDIAN_FILTER_MINMAX_EN
        chk("model_min", 32'(o_min), e.mn);
        chk("model_max", 32'(o_max), e.mx);
`endif
        en1 = 1'b0;
        en2 = 1'b0;
    endtask

    task automatic push_col(input int a, input int b, input int c);
        step(1'b1, 1'b0, a);
        step(1'b1, 1'b0, b);
        step(1'b1, 1'b1, c);
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(o_valid), 0);
        chk("rst_mid_med", 32'(o_med), 0);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        en1    = 1'b0;
        en2    = 1'b0;
        i_data = '0;
        model_reset();

        // Reset state.
        #12;
        chk("rst_med", 32'(o_med), 0);
        chk("rst_valid", 32'(o_valid), 0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);
        chk("idle_med", 32'(o_med), 0);
        chk("idle_valid", 32'(o_valid), 0);

        // Basic window: median 5, valid 3 edges after the last commit.
        push_col(1, 2, 3);
        push_col(7, 8, 5);
        push_col(4, 6, 9);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        chk("s2_valid_early", 32'(o_valid), 0);
        step(1'b0, 1'b0, 0);
        chk("s2_med", 32'(o_med), 5);
        chk("s2_valid", 32'(o_valid), 1);
`ifdef MEDIAN_FILTER_MINMAX_EN
        chk("s2_min", 32'(o_min), 1);
        chk("s2_max", 32'(o_max), 9);
`endif

        // Re-commit the last column three times.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 0);
            chk("s3_med", 32'(o_med), 6);
        end

        // Extremes and all-equal windows.
        push_col(255, 0, 255);
        push_col(0, 255, 0);
        push_col(255, 255, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        chk("s4_extreme_med", 32'(o_med), 255);
        for (int i = 0; i < 3; i++) push_col(8'h80, 8'h80, 8'h80);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);
        chk("s4_equal_med", 32'(o_med), 8'h80);

        // Reset after two commits; three fresh commits rebuild validity.
        push_col(10, 20, 30);
        push_col(40, 50, 60);
        mid_reset();
        push_col(3, 1, 2);
        push_col(9, 9, 9);
        push_col(5, 4, 6);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        chk("s5_valid_early", 32'(o_valid), 0);
        step(1'b0, 1'b0, 0);
        chk("s5_valid", 32'(o_valid), 1);
        chk("s5_med", 32'(o_med), 5);

        // Randomized traffic, including back-to-back commits and one reset.
        for (int i = 0; i < 600; i++) begin
            int d;
            if ($urandom_range(0, 3) == 0)
                d = ($urandom_range(0, 1) == 1) ? 255 : 0;
            else
                d = int'($urandom_range(0, 255));
            if (i == 300) mid_reset();
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
